// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/load-store arbiter onto a single-outstanding split addr/data bus
// Fair tie-break via last_grant; done/ready are registered one-cycle pulses.

module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic              inst_ready_o,
  output logic [DATA_W-1:0] inst_rdata_o,

  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_sel_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_done_o,
  output logic [DATA_W-1:0] data_rdata_o,

  output logic              pause_if_o,
  output logic              pause_mem_o,

  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_addr_ok_i,
  input  logic              bus_data_ok_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_D_ADDR = 3'd1,
    S_D_DATA = 3'd2,
    S_I_ADDR = 3'd3,
    S_I_DATA = 3'd4
  } state_t;

  localparam logic LG_INST = 1'b0;
  localparam logic LG_DATA = 1'b1;

  state_t            r_state;
  state_t            w_next;
  logic              r_last_grant;
  logic              r_we;
  logic [3:0]        r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_data_done;
  logic              r_inst_ready;
  logic [DATA_W-1:0] r_data_rdata;
  logic [DATA_W-1:0] r_inst_rdata;

  logic w_data_req;
  logic w_inst_req;
  logic w_grant_d;
  logic w_grant_i;
  logic w_fin_d;
  logic w_fin_i;

  // A requester still holds its level request during its done cycle; mask it so it is not re-served.
  assign w_data_req = data_req_i & ~r_data_done;
  assign w_inst_req = inst_req_i & ~r_inst_ready;

  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    w_fin_d   = 1'b0;
    w_fin_i   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_data_req && (!w_inst_req || (r_last_grant == LG_INST))) begin
          w_grant_d = 1'b1;
          w_next    = S_D_ADDR;
        end else if (w_inst_req) begin
          w_grant_i = 1'b1;
          w_next    = S_I_ADDR;
        end
      end
      S_D_ADDR: begin
        if (bus_addr_ok_i) begin
          if (bus_data_ok_i) begin
            w_fin_d = 1'b1;
            w_next  = S_IDLE;
          end else begin
            w_next  = S_D_DATA;
          end
        end
      end
      S_D_DATA: begin
        if (bus_data_ok_i) begin
          w_fin_d = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_I_ADDR: begin
        if (bus_addr_ok_i) begin
          if (bus_data_ok_i) begin
            w_fin_i = 1'b1;
            w_next  = S_IDLE;
          end else begin
            w_next  = S_I_DATA;
          end
        end
      end
      S_I_DATA: begin
        if (bus_data_ok_i) begin
          w_fin_i = 1'b1;
          w_next  = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= LG_INST;
      r_we         <= 1'b0;
      r_sel        <= 4'b0000;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_data_done  <= 1'b0;
      r_inst_ready <= 1'b0;
      r_data_rdata <= '0;
      r_inst_rdata <= '0;
    end else begin
      r_data_done  <= w_fin_d;
      r_inst_ready <= w_fin_i;
      if (w_grant_d) begin
        r_we    <= data_we_i;
        r_sel   <= data_sel_i;
        r_addr  <= data_addr_i;
        r_wdata <= data_wdata_i;
      end else if (w_grant_i) begin
        r_we    <= 1'b0;
        r_sel   <= 4'b1111;
        r_addr  <= inst_addr_i;
        r_wdata <= '0;
      end
      if (w_fin_d) begin
        r_last_grant <= LG_DATA;
        if (!r_we) begin
          r_data_rdata <= bus_rdata_i;
        end
      end
      if (w_fin_i) begin
        r_last_grant <= LG_INST;
        r_inst_rdata <= bus_rdata_i;
      end
    end
  end

  assign bus_req_o    = (r_state == S_D_ADDR) || (r_state == S_I_ADDR);
  assign bus_we_o     = r_we;
  assign bus_sel_o    = r_sel;
  assign bus_addr_o   = r_addr;
  assign bus_wdata_o  = r_wdata;

  assign data_done_o  = r_data_done;
  assign data_rdata_o = r_data_rdata;
  assign inst_ready_o = r_inst_ready;
  assign inst_rdata_o = r_inst_rdata;

  assign pause_mem_o  = data_req_i & ~r_data_done;
  assign pause_if_o   = inst_req_i & ~r_inst_ready;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter

module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req_i;
  logic [31:0] inst_addr_i;
  logic        inst_ready_o;
  logic [31:0] inst_rdata_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_sel_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_done_o;
  logic [31:0] data_rdata_o;
  logic        pause_if_o;
  logic        pause_mem_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_addr_ok_i;
  logic        bus_data_ok_i;
  logic [31:0] bus_rdata_i;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req_i   (inst_req_i),
    .inst_addr_i  (inst_addr_i),
    .inst_ready_o (inst_ready_o),
    .inst_rdata_o (inst_rdata_o),
    .data_req_i   (data_req_i),
    .data_we_i    (data_we_i),
    .data_sel_i   (data_sel_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_done_o  (data_done_o),
    .data_rdata_o (data_rdata_o),
    .pause_if_o   (pause_if_o),
    .pause_mem_o  (pause_mem_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_sel_o    (bus_sel_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_addr_ok_i(bus_addr_ok_i),
    .bus_data_ok_i(bus_data_ok_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    int          aw;
    int          dw;
    logic [31:0] rdata;
  } cfg_t;

  bus_t        exp_bus[$];
  cfg_t        cfg_q[$];
  logic [31:0] exp_d[$];
  logic [31:0] exp_i[$];
  logic [31:0] model_d;
  logic [31:0] model_i;
  bit          inject_dok;
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Bus slave: per-transaction address wait and data wait taken from cfg_q.
  initial begin
    int   ph;
    int   cnt;
    cfg_t cur;
    ph = 0;
    cnt = 0;
    cur.aw = 0;
    cur.dw = 0;
    cur.rdata = 32'h0;
    bus_addr_ok_i = 1'b0;
    bus_data_ok_i = 1'b0;
    bus_rdata_i   = 32'h0BAD0BAD;
    forever begin
      @(posedge clk);
      #1;
      bus_addr_ok_i = 1'b0;
      bus_data_ok_i = 1'b0;
      bus_rdata_i   = 32'h0BAD0BAD;
      if (!rst) begin
        ph = 0;
      end else begin
        if (ph == 0 && bus_req_o) begin
          if (cfg_q.size() > 0) cur = cfg_q.pop_front();
          cnt = 0;
          ph = 1;
        end
        if (ph == 1) begin
          if (cnt == cur.aw) begin
            bus_addr_ok_i = 1'b1;
            cnt = 0;
            if (cur.dw == 0) begin
              bus_data_ok_i = 1'b1;
              bus_rdata_i   = cur.rdata;
              ph = 0;
            end else begin
              ph = 2;
            end
          end else begin
            cnt++;
          end
        end else if (ph == 2) begin
          cnt++;
          if (cnt == cur.dw) begin
            bus_data_ok_i = 1'b1;
            bus_rdata_i   = cur.rdata;
            ph = 0;
          end
        end
        if (inject_dok) bus_data_ok_i = 1'b1;
      end
    end
  end

  // Monitor: bus payload against expected queue every request cycle; done/ready against expected data.
  initial begin
    bus_t        eb;
    logic [31:0] ev;
    bit          prev_dd;
    bit          prev_ir;
    prev_dd = 0;
    prev_ir = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus_req_o) begin
          if (exp_bus.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bus_req addr=%h", bus_addr_o);
          end else begin
            eb = exp_bus[0];
            chk("bus_payload", 160'({bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}),
                160'({eb.we, eb.sel, eb.addr, eb.wdata}));
            if (bus_addr_ok_i) eb = exp_bus.pop_front();
          end
        end
        if (data_done_o) begin
          if (prev_dd) begin
            checks++;
            errors++;
            $display("FAIL data_done_width got=2+ cycles exp=1");
          end else if (exp_d.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_data_done got=1 exp=0");
          end else begin
            ev = exp_d.pop_front();
            chk("data_rdata", 160'(data_rdata_o), 160'(ev));
          end
        end
        if (inst_ready_o) begin
          if (prev_ir) begin
            checks++;
            errors++;
            $display("FAIL inst_ready_width got=2+ cycles exp=1");
          end else if (exp_i.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_inst_ready got=1 exp=0");
          end else begin
            ev = exp_i.pop_front();
            chk("inst_rdata", 160'(inst_rdata_o), 160'(ev));
          end
        end
      end
      prev_dd = data_done_o;
      prev_ir = inst_ready_o;
    end
  end

  task automatic push_d(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int aw, input int dw);
    bus_t b;
    cfg_t c;
    b.we = we; b.sel = sel; b.addr = addr; b.wdata = wdata;
    c.aw = aw; c.dw = dw; c.rdata = rdata;
    exp_bus.push_back(b);
    cfg_q.push_back(c);
    if (!we) model_d = rdata;
    exp_d.push_back(model_d);
    data_we_i = we; data_sel_i = sel; data_addr_i = addr; data_wdata_i = wdata;
  endtask

  task automatic push_i(input logic [31:0] addr, input logic [31:0] rdata, input int aw, input int dw);
    bus_t b;
    cfg_t c;
    b.we = 1'b0; b.sel = 4'b1111; b.addr = addr; b.wdata = 32'h0;
    c.aw = aw; c.dw = dw; c.rdata = rdata;
    exp_bus.push_back(b);
    cfg_q.push_back(c);
    model_i = rdata;
    exp_i.push_back(rdata);
    inst_addr_i = addr;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Called at cycle 0 (just after an edge); returns edges until each done/ready was seen.
  task automatic run(input bit dr, input bit ir, input int drop_at, output int d_lat, output int i_lat);
    bit dp;
    bit ip;
    dp = dr;
    ip = ir;
    d_lat = -1;
    i_lat = -1;
    data_req_i = dr;
    inst_req_i = ir;
    for (int c = 1; c <= 100 && (dp || ip); c++) begin
      @(posedge clk);
      #2;
      if (dp) begin
        if (data_done_o) begin
          d_lat = c;
          if (data_req_i) chk("pause_mem_on_done", 160'(pause_mem_o), 160'(0));
          data_req_i = 1'b0;
          dp = 0;
        end else if (data_req_i && !pause_mem_o) begin
          checks++;
          errors++;
          $display("FAIL pause_mem_waiting got=0 exp=1 cycle=%0d", c);
        end
        if (c == drop_at) data_req_i = 1'b0;
      end
      if (ip) begin
        if (inst_ready_o) begin
          i_lat = c;
          chk("pause_if_on_ready", 160'(pause_if_o), 160'(0));
          inst_req_i = 1'b0;
          ip = 0;
        end else if (!pause_if_o) begin
          checks++;
          errors++;
          $display("FAIL pause_if_waiting got=0 exp=1 cycle=%0d", c);
        end
      end
    end
    if (dp) begin
      checks++; errors++;
      $display("FAIL data_timeout got=no_done exp=done");
      data_req_i = 1'b0;
    end
    if (ip) begin
      checks++; errors++;
      $display("FAIL inst_timeout got=no_ready exp=ready");
      inst_req_i = 1'b0;
    end
  endtask

  initial begin
    int dl;
    int il;
    int seen;
    bus_t b;
    cfg_t c;
    checks = 0;
    errors = 0;
    model_d = 32'h0;
    model_i = 32'h0;
    inject_dok = 0;
    rst = 1'b0;
    inst_req_i = 1'b0;
    inst_addr_i = 32'h0;
    data_req_i = 1'b0;
    data_we_i = 1'b0;
    data_sel_i = 4'h0;
    data_addr_i = 32'h0;
    data_wdata_i = 32'h0;

    #3;
    chk("reset_outputs", 160'({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
                              inst_ready_o, data_done_o, inst_rdata_o, data_rdata_o,
                              pause_if_o, pause_mem_o}), 160'(0));
    idle(2);
    rst = 1'b1;
    idle(1);

    // Tie after reset: data first, then fetch.
    push_d(1'b0, 4'b1111, 32'h0000_2000, 32'h0, 32'h1111_2222, 0, 0);
    push_i(32'h0000_0100, 32'h3333_4444, 0, 0);
    run(1, 1, -1, dl, il);
    chk("tie1_data_lat", 160'(dl), 160'(2));
    chk("tie1_inst_lat", 160'(il), 160'(4));
    idle(2);

    // Zero-wait single load.
    push_d(1'b0, 4'b1111, 32'h0000_2004, 32'h0, 32'h5555_6666, 0, 0);
    run(1, 0, -1, dl, il);
    chk("zero_wait_lat", 160'(dl), 160'(2));
    idle(2);

    // Tie with data granted last: fetch first.
    push_i(32'h0000_0104, 32'h7777_8888, 0, 0);
    push_d(1'b0, 4'b1111, 32'h0000_2008, 32'h0, 32'h9999_AAAA, 0, 0);
    run(1, 1, -1, dl, il);
    chk("tie2_inst_lat", 160'(il), 160'(2));
    chk("tie2_data_lat", 160'(dl), 160'(4));
    idle(2);

    // Single load, addr_ok cycle 2, data_ok cycle 4.
    push_d(1'b0, 4'b1111, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 1, 2);
    run(1, 0, -1, dl, il);
    chk("load_lat", 160'(dl), 160'(5));
    chk("load_rdata_held", 160'(data_rdata_o), 160'(32'hDEAD_BEEF));
    idle(2);

    // Store with slow address accept; load data must stay.
    push_d(1'b1, 4'b0100, 32'h0000_3000, 32'hAAAA_AAAA, 32'h0BAD_F00D, 5, 1);
    run(1, 0, -1, dl, il);
    chk("store_lat", 160'(dl), 160'(8));
    chk("store_rdata_held", 160'(data_rdata_o), 160'(32'hDEAD_BEEF));
    idle(2);

    // Store with empty byte select still goes to the bus.
    push_d(1'b1, 4'b0000, 32'h0000_3004, 32'h1234_5678, 32'h0BAD_F00D, 0, 1);
    run(1, 0, -1, dl, il);
    chk("sel0_lat", 160'(dl), 160'(3));
    idle(2);

    // Request dropped after grant: transaction still completes once.
    push_d(1'b0, 4'b1111, 32'h0000_4000, 32'h0, 32'h1357_9BDF, 3, 1);
    run(1, 0, 2, dl, il);
    chk("drop_lat", 160'(dl), 160'(6));
    chk("drop_rdata", 160'(data_rdata_o), 160'(32'h1357_9BDF));
    idle(3);

    // Reset during data phase.
    b.we = 1'b0; b.sel = 4'b1111; b.addr = 32'h0000_5000; b.wdata = 32'h0;
    c.aw = 0; c.dw = 20; c.rdata = 32'hCAFE_CAFE;
    exp_bus.push_back(b);
    cfg_q.push_back(c);
    data_we_i = 1'b0; data_sel_i = 4'b1111; data_addr_i = 32'h0000_5000;
    data_req_i = 1'b1;
    idle(3);
    chk("in_data_phase_no_req", 160'(bus_req_o), 160'(0));
    #1;
    rst = 1'b0;
    data_req_i = 1'b0;
    #1;
    chk("reset_in_flight", 160'({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
                                inst_ready_o, data_done_o, inst_rdata_o, data_rdata_o}), 160'(0));
    model_d = 32'h0;
    model_i = 32'h0;
    void'(cfg_q.size());
    idle(2);
    rst = 1'b1;
    inject_dok = 1;
    idle(1);
    inject_dok = 0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      if (data_done_o || bus_req_o) seen++;
    end
    chk("no_done_after_reset", 160'(seen), 160'(0));
    chk("rdata_after_reset", 160'(data_rdata_o), 160'(0));

    // Arbitration resumes; last_grant back to inst so data wins the tie.
    push_d(1'b0, 4'b1111, 32'h0000_6000, 32'h0, 32'h2468_ACE0, 0, 1);
    push_i(32'h0000_0200, 32'hFEDC_BA98, 1, 0);
    run(1, 1, -1, dl, il);
    chk("post_reset_data_lat", 160'(dl), 160'(3));
    chk("post_reset_inst_lat", 160'(il), 160'(6));
    idle(3);

    chk("exp_bus_empty", 160'(exp_bus.size()), 160'(0));
    chk("exp_d_empty", 160'(exp_d.size()), 160'(0));
    chk("exp_i_empty", 160'(exp_i.size()), 160'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port inst_req_i  in  1  fetch read request, level, held until inst_ready_o.
REQ-006 SHALL have port inst_addr_i  in  ADDR_W  fetch address.
REQ-007 SHALL have ports inst_ready_o (out, 1, fetch done pulse) and inst_rdata_o (out, DATA_W, fetch data).
REQ-008 SHALL have ports data_req_i (in, 1, MEM-stage ram enable, level), data_we_i (in, 1), data_sel_i (in, 4, byte select), data_addr_i (in, ADDR_W), data_wdata_i (in, DATA_W).
REQ-009 SHALL have ports data_done_o (out, 1, done pulse) and data_rdata_o (out, DATA_W, load data).
REQ-010 SHALL have ports pause_if_o and pause_mem_o (out, 1, pipeline stall requests).
REQ-011 SHALL have bus ports bus_req_o, bus_we_o (out, 1), bus_sel_o (out, 4), bus_addr_o (out, ADDR_W), bus_wdata_o (out, DATA_W), bus_addr_ok_i, bus_data_ok_i (in, 1), bus_rdata_i (in, DATA_W).

Function
REQ-012 SHALL implement FSM states IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA.
REQ-013 SHALL, in IDLE, grant data if only data_req_i, inst if only inst_req_i; on both, grant the requester not granted last (last_grant register).
REQ-014 SHALL, on grant, latch that requester's we/sel/addr/wdata (fetch: we=0, sel=4'b1111) into payload registers and enter D_ADDR or I_ADDR next cycle.
REQ-015 SHALL assert bus_req_o only in D_ADDR/I_ADDR, driving bus_* from payload registers, stable until bus_addr_ok_i.
REQ-016 SHALL move *_ADDR -> *_DATA on bus_addr_ok_i=1 without bus_data_ok_i.
REQ-017 SHALL, on bus_data_ok_i=1 in *_DATA, or with bus_addr_ok_i in the same cycle in *_ADDR, pulse the owner's done/ready for exactly one cycle, register bus_rdata_i into its rdata output (reads only), update last_grant, return to IDLE.
REQ-018 SHALL hold data_rdata_o/inst_rdata_o unchanged on writes and between transactions.
REQ-019 SHALL produce done/ready registered: one cycle after bus_data_ok_i; minimum grant-to-done latency 3 cycles (IDLE grant, ADDR, done).
REQ-020 SHALL drive pause_mem_o = data_req_i & ~data_done_o and pause_if_o = inst_req_i & ~inst_ready_o, combinationally.
REQ-021 SHALL ignore bus_data_ok_i in IDLE and *_ADDR without bus_addr_ok_i, and bus_addr_ok_i in *_DATA.
REQ-022 SHALL complete a started transaction even if its request drops; done still pulses and is discarded by the requester.
REQ-023 SHALL never issue a new bus_req_o before the previous transaction's data_ok (one outstanding).
REQ-024 SHALL, on 0 written to data_sel_i for a write, still issue the bus cycle unchanged (checking belongs to mem).

Reset
REQ-025 SHALL, on rst=0, immediately force: state IDLE, bus_req_o=0, bus_we_o=0, bus_sel_o=0, bus_addr_o=0, bus_wdata_o=0, inst_ready_o=0, data_done_o=0, inst_rdata_o=0, data_rdata_o=0, last_grant=inst.
REQ-026 SHALL abandon any in-flight transaction on reset; no done pulse after release.
REQ-027 SHALL resume arbitration the first rising edge after rst returns to 1.

Verification
REQ-028 Single load: data_req_i=1, we=0, addr=0x1000; bus addr_ok cycle 2, data_ok cycle 4 with rdata=0xDEADBEEF -> data_done_o pulse cycle 5, data_rdata_o=0xDEADBEEF, pause_mem_o low from cycle 5.
REQ-029 Tie after reset: inst and data both request in cycle 0 -> data served first (bus_addr_o=data addr), then fetch; next tie grants fetch first.
REQ-030 Zero-wait slave: addr_ok and data_ok same cycle as bus_req_o -> done 1 cycle later, FSM skips *_DATA.
REQ-031 Store sel=4'b0100, wdata=0xAAAAAAAA -> bus_we_o=1, bus_sel_o=4'b0100 held through 5 addr_ok-low cycles; data_rdata_o unchanged.
REQ-032 Reset asserted in D_DATA -> bus_req_o=0 and all outputs zero same cycle; later data_ok ignored, no done pulse.
REQ-033 Request drop: data_req_i deasserted after grant -> bus transaction completes, data_done_o pulses once, FSM back to IDLE.
